// File: rtl/affine_point_encoder.sv
// Streams an affine point (x, y) out as a SEC1 octet string, one byte per
// valid/ready handshake. Supports compressed, uncompressed and the
// point-at-infinity (single 0x00) encodings.
module affine_point_encoder #(
  parameter int unsigned COORD_W = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  input  logic               compress,
  output logic               busy,
  output logic [7:0]         out_byte,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               done
);

  localparam int unsigned NB    = COORD_W / 8;
  localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_XB,
    S_YB,
    S_FIN
  } state_e;

  state_e             state_q;
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic               compress_q;
  logic [IDX_W-1:0]   idx_q;
  logic               busy_q;
  logic [7:0]         out_byte_q;
  logic               out_valid_q;
  logic               out_last_q;
  logic               done_q;

  logic               accept;
  logic               inf_in;
  logic               inf_q;
  logic [IDX_W-1:0]   idx_inc;

  // Byte k of a coordinate, most significant byte first.
  function automatic logic [7:0] coord_byte(input logic [COORD_W-1:0] c,
                                            input logic [IDX_W-1:0]   k);
    logic [COORD_W-1:0] sh;
    sh = c << {k, 3'b000};
    return sh[COORD_W-1 -: 8];
  endfunction

  // Handshake and point-at-infinity detection.
  assign accept  = out_valid_q & out_ready;
  assign inf_in  = (x_in == '0) && (y_in == '0);
  assign inf_q   = (x_q == '0) && (y_q == '0);
  assign idx_inc = idx_q + IDX_W'(1);

  // Encoder FSM; every output is computed one cycle ahead so it is registered
  // and holds steady while the sink stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      compress_q  <= 1'b0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      out_byte_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            x_q         <= x_in;
            y_q         <= y_in;
            compress_q  <= compress;
            idx_q       <= '0;
            busy_q      <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= S_HDR;
            if (inf_in) begin
              out_byte_q <= 8'h00;
              out_last_q <= 1'b1;
            end else if (compress) begin
              out_byte_q <= 8'h02 | {7'd0, y_in[0]};
              out_last_q <= 1'b0;
            end else begin
              out_byte_q <= 8'h04;
              out_last_q <= 1'b0;
            end
          end
        end

        S_HDR: begin
          if (accept) begin
            if (inf_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= S_FIN;
            end else begin
              idx_q      <= '0;
              out_byte_q <= coord_byte(x_q, '0);
              out_last_q <= compress_q && (IDX_LAST == '0);
              state_q    <= S_XB;
            end
          end
        end

        S_XB: begin
          if (accept) begin
            if (idx_q == IDX_LAST) begin
              if (compress_q) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
                busy_q      <= 1'b0;
                done_q      <= 1'b1;
                state_q     <= S_FIN;
              end else begin
                idx_q      <= '0;
                out_byte_q <= coord_byte(y_q, '0);
                out_last_q <= (IDX_LAST == '0);
                state_q    <= S_YB;
              end
            end else begin
              idx_q      <= idx_inc;
              out_byte_q <= coord_byte(x_q, idx_inc);
              out_last_q <= compress_q && (idx_inc == IDX_LAST);
            end
          end
        end

        S_YB: begin
          if (accept) begin
            if (idx_q == IDX_LAST) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= S_FIN;
            end else begin
              idx_q      <= idx_inc;
              out_byte_q <= coord_byte(y_q, idx_inc);
              out_last_q <= (idx_inc == IDX_LAST);
            end
          end
        end

        S_FIN: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_byte  = out_byte_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_affine_point_encoder.sv
// Directed bench for affine_point_encoder: secp256k1 generator in both
// encodings, a small odd-y point, infinity, a stalling sink, and a
// restart/abort sequence.
module tb_affine_point_encoder;

  localparam logic [255:0] GX =
    256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam logic [255:0] GY =
    256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [255:0] x_in;
  logic [255:0] y_in;
  logic         compress;
  logic         busy;
  logic [7:0]   out_byte;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         done;

  int errors;
  int checks;

  logic [527:0] rx_data;
  int           rx_n;
  int           rx_lasts;
  int           rx_last_pos;
  int           rx_done_cyc;
  int           rx_stall_bad;
  int           rx_busy1;

  affine_point_encoder #(.COORD_W(256)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .compress  (compress),
    .busy      (busy),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [527:0] got, input logic [527:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Launch one encoding and collect accepted bytes. Optionally re-pulse start
  // after pulse_at bytes, or assert reset after abort_at bytes.
  task automatic run_enc(input logic [255:0] x, input logic [255:0] y, input logic comp,
                         input bit rnd, input int pulse_at, input int abort_at);
    logic       pv_stall;
    logic [7:0] pb;
    logic       pl;
    bit         pulsed;
    rx_data = '0; rx_n = 0; rx_lasts = 0; rx_last_pos = 0;
    rx_done_cyc = -1; rx_stall_bad = 0; rx_busy1 = -1;
    pv_stall = 1'b0; pb = 8'h00; pl = 1'b0; pulsed = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    x_in = x; y_in = y; compress = comp; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 400; c++) begin
      if (c == 1) rx_busy1 = int'(busy);
      if (done) begin
        rx_done_cyc = c;
        break;
      end
      if (pv_stall && (!out_valid || out_byte != pb || out_last != pl)) rx_stall_bad++;
      if (pulse_at >= 0 && !pulsed && rx_n == pulse_at) begin
        start = 1'b1; x_in = '1; y_in = '1; compress = 1'b0; pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (abort_at >= 0 && rx_n == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_valid_drop", 528'(out_valid), 528'd0);
        check("abort_no_done", 528'(done), 528'd0);
        break;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        rx_data = {rx_data[519:0], out_byte};
        rx_n++;
        if (out_last) begin
          rx_lasts++;
          rx_last_pos = rx_n;
        end
      end
      pv_stall = out_valid && !out_ready;
      pb = out_byte;
      pl = out_last;
      @(posedge clk); #1;
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b0; start = 1'b0; x_in = '0; y_in = '0; compress = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  528'(busy),      528'd0);
    check("rst_valid", 528'(out_valid), 528'd0);
    check("rst_last",  528'(out_last),  528'd0);
    check("rst_done",  528'(done),      528'd0);
    check("rst_byte",  528'(out_byte),  528'd0);
    rst_n = 1'b1;

    // Generator, compressed
    run_enc(GX, GY, 1'b1, 1'b0, -1, -1);
    check("t1_data",  rx_data, {264'h0, 8'h02, GX});
    check("t1_count", 528'(rx_n), 528'd33);
    check("t1_lasts", 528'(rx_lasts), 528'd1);
    check("t1_lastp", 528'(rx_last_pos), 528'd33);
    check("t1_done",  528'(rx_done_cyc), 528'd34);
    check("t1_busy1", 528'(rx_busy1), 528'd1);
    @(posedge clk); #1;
    check("t1_busy_after", 528'(busy), 528'd0);
    check("t1_done_pulse", 528'(done), 528'd0);

    // Generator, uncompressed
    run_enc(GX, GY, 1'b0, 1'b0, -1, -1);
    check("t2_data",  rx_data, {8'h00, 8'h04, GX, GY});
    check("t2_count", 528'(rx_n), 528'd65);
    check("t2_lasts", 528'(rx_lasts), 528'd1);
    check("t2_lastp", 528'(rx_last_pos), 528'd65);
    check("t2_done",  528'(rx_done_cyc), 528'd66);

    // Small point with odd y, compressed
    run_enc(256'd5, 256'd1, 1'b1, 1'b0, -1, -1);
    check("t3_data",  rx_data, {264'h0, 8'h03, 256'd5});
    check("t3_count", 528'(rx_n), 528'd33);
    check("t3_done",  528'(rx_done_cyc), 528'd34);

    // Point at infinity
    run_enc(256'd0, 256'd0, 1'b1, 1'b0, -1, -1);
    check("t4_data",  rx_data, 528'd0);
    check("t4_count", 528'(rx_n), 528'd1);
    check("t4_lastp", 528'(rx_last_pos), 528'd1);
    check("t4_done",  528'(rx_done_cyc), 528'd2);

    // Uncompressed generator through a stalling sink
    run_enc(GX, GY, 1'b0, 1'b1, -1, -1);
    check("t5_data",  rx_data, {8'h00, 8'h04, GX, GY});
    check("t5_count", 528'(rx_n), 528'd65);
    check("t5_lasts", 528'(rx_lasts), 528'd1);
    check("t5_stall", 528'(rx_stall_bad), 528'd0);
    check("t5_done_seen", 528'(rx_done_cyc > 0), 528'd1);

    // Restart pulse while busy, then reset mid-stream
    run_enc(GX, GY, 1'b1, 1'b0, 10, 20);
    check("t6_data",  rx_data, {368'h0, 8'h02, GX[255:104]});
    check("t6_count", 528'(rx_n), 528'd20);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    begin
      int spurious;
      spurious = 0;
      for (int i = 0; i < 5; i++) begin
        if (done || out_valid || busy) spurious++;
        @(posedge clk); #1;
      end
      check("t6_quiet", 528'(spurious), 528'd0);
    end
    run_enc(256'd5, 256'd1, 1'b1, 1'b0, -1, -1);
    check("t6_re_data", rx_data, {264'h0, 8'h03, 256'd5});
    check("t6_re_done", 528'(rx_done_cyc), 528'd34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
